// File: rtl/jtframe_romload_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romload_pkg
//  Description : Shared types and constants for the ROM download stager.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_romload_pkg;

    // One queued SDRAM byte write: word address, active-low lane mask, byte
    typedef struct packed {
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } romload_entry_t;

    // FSM encoding kept as plain 2-bit constants for legacy tools
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        TAIL  = ST_TAIL
    } romload_st_e;

    // Active-low byte enables: clear bit selects the lane that is written
    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;

    // Even byte addresses land in the low lane, odd ones in the high lane
    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_romload_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romload_fifo
//  Description : Small first-word-fall-through FIFO of download entries.
//                A push while full is only accepted if a pop happens in the
//                same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_romload_fifo
    import jtframe_romload_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  romload_entry_t din,
    input  logic           pop,
    output romload_entry_t dout,
    output logic           full,
    output logic           empty
);

    localparam int             c_depth_i = 1 << AW;
    localparam logic [AW:0]    c_depth   = (AW+1)'(c_depth_i);

    romload_entry_t    r_mem [c_depth_i];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; reset flushes the queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_romload.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_romload
//  Description : Converts the ioctl byte stream into SDRAM byte writes.
//                Strips the header, range-checks against ROM_END, queues
//                entries, hands them to the SDRAM port and keeps dwnld_busy
//                up until everything is committed plus a settle tail.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_romload
    import jtframe_romload_pkg::*;
#(
    parameter int          HEADER      = 0,
    parameter logic [22:0] ROM_END     = 23'h40_0000,
    parameter int          FIFO_AW     = 2,
    parameter int          POST_CYCLES = 16
) (
    input  logic        clk_rom,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        sdram_ack,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        dwnld_busy,
    output logic        overflow
);

    localparam logic [22:0]          c_header = 23'(HEADER);
    localparam int                   c_cnt_w  = (POST_CYCLES > 0) ? $clog2(POST_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0]   c_post   = c_cnt_w'(POST_CYCLES);

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_committed;
    logic                r_dl_q;

    logic [22:0]         w_rel;
    logic                w_accept;
    logic                w_ack;
    logic                w_pop;
    logic                w_lost;
    logic                w_dl_rise;
    logic                w_full;
    logic                w_empty;
    romload_entry_t      w_in_entry;
    romload_entry_t      w_head;

    assign w_rel      = ioctl_addr - c_header;
    assign w_accept   = downloading & ioctl_wr & (ioctl_addr >= c_header) & (w_rel < ROM_END);
    assign w_in_entry = '{addr: w_rel[22:1], mask: byte_mask(w_rel[0]), data: ioctl_data};
    assign w_ack      = sdram_ack & prog_we;
    // Outside WRITE the head is taken as soon as it exists; in WRITE only on ack
    assign w_pop      = ~w_empty & ((r_state != ST_WRITE) | w_ack);
    assign w_lost     = w_accept & w_full & ~w_pop;
    assign w_dl_rise  = downloading & ~r_dl_q;
    assign dwnld_busy = downloading | ~w_empty | (r_state != ST_IDLE);

    jtframe_romload_fifo #(
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk    (clk_rom),
        .rst_n  (rst_n),
        .push   (w_accept),
        .din    (w_in_entry),
        .pop    (w_pop),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Edge detector for the start of a download window
    always_ff @(posedge clk_rom) begin
        if (!rst_n) r_dl_q <= 1'b0;
        else        r_dl_q <= downloading;
    end

    // Sticky overflow; a byte lost in the same cycle as a new window still counts
    always_ff @(posedge clk_rom) begin
        if (!rst_n)         overflow <= 1'b0;
        else if (w_lost)    overflow <= 1'b1;
        else if (w_dl_rise) overflow <= 1'b0;
    end

    // Write port: every pop loads a fresh entry, an ack with nothing queued drops the request
    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_we   <= 1'b0;
        end else if (w_pop) begin
            prog_addr <= w_head.addr;
            prog_data <= w_head.data;
            prog_mask <= w_head.mask;
            prog_we   <= 1'b1;
        end else if (w_ack) begin
            prog_we   <= 1'b0;
        end
    end

    // Sequencer: IDLE/WRITE/TAIL plus the settle counter and committed flag
    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_committed <= 1'b0;
        end else begin
            if (w_dl_rise) r_committed <= 1'b0;
            if (w_ack)     r_committed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_WRITE;
                    end else if (!downloading && r_committed) begin
                        r_state <= ST_TAIL;
                        r_cnt   <= '0;
                    end
                end
                ST_WRITE: begin
                    if (w_ack && w_empty) begin
                        r_state <= downloading ? ST_IDLE : ST_TAIL;
                        r_cnt   <= '0;
                    end
                end
                ST_TAIL: begin
                    // Counting 0..POST_CYCLES makes busy drop POST_CYCLES+1 edges after the last ack
                    if (!w_empty) begin
                        r_state <= ST_WRITE;
                    end else if (r_cnt == c_post) begin
                        r_state     <= ST_IDLE;
                        r_committed <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_romload.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_jtframe_romload
//  Description : Directed self-checking bench for jtframe_romload
//                (HEADER=4, ROM_END=8, FIFO_AW=2, POST_CYCLES=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_romload;

    logic        clk_rom = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [22:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        sdram_ack;
    logic        ack_man = 1'b0;
    logic        ack_auto = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        dwnld_busy;
    logic        overflow;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] wlog [$];

    always #5 clk_rom = ~clk_rom;

    assign sdram_ack = ack_auto ? prog_we : ack_man;

    jtframe_romload #(
        .HEADER      (4),
        .ROM_END     (23'd8),
        .FIFO_AW     (2),
        .POST_CYCLES (16)
    ) dut (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .sdram_ack   (sdram_ack),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    // Record every write that the next rising edge will commit
    always @(negedge clk_rom) begin
        if (prog_we && sdram_ack) wlog.push_back({prog_addr, prog_mask, prog_data});
    end

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic drive_byte(input logic [22:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!dwnld_busy) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run += 6;
        if (prog_addr !== 22'd0)   begin tests_failed++; $display("FAIL rst_addr: got %h want 0", prog_addr); end
        if (prog_data !== 8'd0)    begin tests_failed++; $display("FAIL rst_data: got %h want 0", prog_data); end
        if (prog_mask !== 2'b11)   begin tests_failed++; $display("FAIL rst_mask: got %b want 11", prog_mask); end
        if (prog_we !== 1'b0)      begin tests_failed++; $display("FAIL rst_we: got %b want 0", prog_we); end
        if (dwnld_busy !== 1'b0)   begin tests_failed++; $display("FAIL rst_busy: got %b want 0", dwnld_busy); end
        if (overflow !== 1'b0)     begin tests_failed++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        rst_n = 1'b1;
        tick();
    endtask

    // wr driven after edge N: pushed at N+1, prog_we up after N+2
    task automatic test_latency();
        bit ok;
        downloading = 1'b1;
        tick();
        wlog.delete();
        ioctl_addr = 23'd4;
        ioctl_data = 8'hA5;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tests_run++;
        if (prog_we !== 1'b0) begin tests_failed++; $display("FAIL lat_early: prog_we got %b want 0", prog_we); end
        tick();
        tests_run += 2;
        if (prog_we !== 1'b1) begin tests_failed++; $display("FAIL lat_we: prog_we got %b want 1", prog_we); end
        if ({prog_addr, prog_mask, prog_data} !== {22'd0, 2'b10, 8'hA5}) begin
            tests_failed++;
            $display("FAIL lat_word: got %h want %h", {prog_addr, prog_mask, prog_data}, {22'd0, 2'b10, 8'hA5});
        end
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        tests_run += 2;
        if (prog_we !== 1'b0) begin tests_failed++; $display("FAIL lat_drop: prog_we got %b want 0", prog_we); end
        if (wlog.size() != 1) begin tests_failed++; $display("FAIL lat_count: got %0d want 1", wlog.size()); end
        downloading = 1'b0;
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL lat_idle: busy got 1 want 0 (timeout)"); end
    endtask

    task automatic test_header_strip();
        bit ok;
        logic [31:0] exp [4];
        logic [31:0] got;
        exp = '{{22'd0, 2'b10, 8'h14}, {22'd0, 2'b01, 8'h15},
                {22'd1, 2'b10, 8'h16}, {22'd1, 2'b01, 8'h17}};
        downloading = 1'b1;
        tick();
        ack_auto = 1'b1;
        wlog.delete();
        for (int i = 0; i < 8; i++) drive_byte(23'(i), 8'h10 + 8'(i));
        downloading = 1'b0;
        wait_idle(ok);
        ack_auto = 1'b0;
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL hdr_idle: busy got 1 want 0 (timeout)"); end
        if (wlog.size() != 4) begin tests_failed++; $display("FAIL hdr_count: got %0d want 4", wlog.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < wlog.size()) ? wlog[i] : 32'hxxxx_xxxx;
            tests_run++;
            if (got !== exp[i]) begin tests_failed++; $display("FAIL hdr_w%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    // The head entry sits in prog_* while the FIFO fills behind it: 1 + 4 kept, 1 lost
    task automatic test_overflow();
        bit ok;
        logic [31:0] exp [5];
        logic [31:0] got;
        exp = '{{22'd0, 2'b10, 8'h20}, {22'd0, 2'b01, 8'h21}, {22'd1, 2'b10, 8'h22},
                {22'd1, 2'b01, 8'h23}, {22'd2, 2'b10, 8'h24}};
        downloading = 1'b1;
        tick();
        ack_man = 1'b0;
        wlog.delete();
        for (int i = 0; i < 6; i++) drive_byte(23'd4 + 23'(i), 8'h20 + 8'(i));
        tick();
        tests_run += 2;
        if (overflow !== 1'b1)     begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        if (prog_data !== 8'h20)   begin tests_failed++; $display("FAIL ovf_head: got %h want 20", prog_data); end
        ack_auto = 1'b1;
        downloading = 1'b0;
        wait_idle(ok);
        ack_auto = 1'b0;
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL ovf_idle: busy got 1 want 0 (timeout)"); end
        if (wlog.size() != 5) begin tests_failed++; $display("FAIL ovf_count: got %0d want 5", wlog.size()); end
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        for (int i = 0; i < 5; i++) begin
            got = (i < wlog.size()) ? wlog[i] : 32'hxxxx_xxxx;
            tests_run++;
            if (got !== exp[i]) begin tests_failed++; $display("FAIL ovf_w%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_slow_ack();
        bit ok;
        bit stable;
        bit seen;
        logic [31:0] snap;
        logic [31:0] exp [3];
        logic [31:0] got;
        exp = '{{22'd2, 2'b10, 8'h30}, {22'd2, 2'b01, 8'h31}, {22'd3, 2'b10, 8'h32}};
        downloading = 1'b1;
        tick();
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL slow_ovf_clr: got %b want 0", overflow); end
        ack_man = 1'b0;
        wlog.delete();
        for (int i = 0; i < 3; i++) drive_byte(23'd8 + 23'(i), 8'h30 + 8'(i));
        for (int w = 0; w < 3; w++) begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                if (prog_we) seen = 1'b1;
                else tick();
            end
            tests_run++;
            if (!seen) begin tests_failed++; $display("FAIL slow_we%0d: prog_we got 0 want 1 (timeout)", w); end
            snap = {prog_addr, prog_mask, prog_data};
            stable = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (prog_we !== 1'b1 || {prog_addr, prog_mask, prog_data} !== snap) stable = 1'b0;
            end
            tests_run++;
            if (!stable) begin tests_failed++; $display("FAIL slow_hold%0d: got %h want %h held", w, {prog_addr, prog_mask, prog_data}, snap); end
            ack_man = 1'b1;
            tick();
            ack_man = 1'b0;
        end
        downloading = 1'b0;
        wait_idle(ok);
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL slow_idle: busy got 1 want 0 (timeout)"); end
        if (wlog.size() != 3) begin tests_failed++; $display("FAIL slow_count: got %0d want 3", wlog.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wlog.size()) ? wlog[i] : 32'hxxxx_xxxx;
            tests_run++;
            if (got !== exp[i]) begin tests_failed++; $display("FAIL slow_w%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    // addr 12 -> b=8 dropped, addr 3 inside header dropped, addr 11 -> b=7 high lane
    task automatic test_rom_end();
        bit ok;
        logic [31:0] got;
        downloading = 1'b1;
        tick();
        ack_auto = 1'b1;
        wlog.delete();
        drive_byte(23'd12, 8'h40);
        drive_byte(23'd3,  8'h41);
        drive_byte(23'd11, 8'h42);
        tick();
        downloading = 1'b0;
        wait_idle(ok);
        got = (wlog.size() > 0) ? wlog[0] : 32'hxxxx_xxxx;
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL end_idle: busy got 1 want 0 (timeout)"); end
        if (wlog.size() != 1) begin tests_failed++; $display("FAIL end_count: got %0d want 1", wlog.size()); end
        if (got !== {22'd3, 2'b01, 8'h42}) begin tests_failed++; $display("FAIL end_w0: got %h want %h", got, {22'd3, 2'b01, 8'h42}); end
        drive_byte(23'd5, 8'h50);
        tick();
        tick();
        ack_auto = 1'b0;
        tests_run += 3;
        if (prog_we !== 1'b0)    begin tests_failed++; $display("FAIL nodl_we: got %b want 0", prog_we); end
        if (dwnld_busy !== 1'b0) begin tests_failed++; $display("FAIL nodl_busy: got %b want 0", dwnld_busy); end
        if (wlog.size() != 1)    begin tests_failed++; $display("FAIL nodl_count: got %0d want 1", wlog.size()); end
    endtask

    task automatic test_tail_timing();
        logic [31:0] got;
        logic        exp_busy;
        downloading = 1'b1;
        tick();
        ack_man = 1'b0;
        wlog.delete();
        drive_byte(23'd4, 8'h60);
        drive_byte(23'd5, 8'h61);
        drive_byte(23'd6, 8'h62);
        downloading = 1'b0;
        ack_man = 1'b1;
        tick();
        tick();
        tick();
        ack_man = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_busy = (k < 17);
            tests_run++;
            if (dwnld_busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL tail_busy_e%0d: got %b want %b", k, dwnld_busy, exp_busy);
            end
        end
        got = (wlog.size() > 2) ? wlog[2] : 32'hxxxx_xxxx;
        tests_run += 2;
        if (wlog.size() != 3) begin tests_failed++; $display("FAIL tail_count: got %0d want 3", wlog.size()); end
        if (got !== {22'd1, 2'b10, 8'h62}) begin tests_failed++; $display("FAIL tail_w2: got %h want %h", got, {22'd1, 2'b10, 8'h62}); end
    endtask

    task automatic test_reset_mid();
        downloading = 1'b1;
        tick();
        ack_man = 1'b0;
        wlog.delete();
        drive_byte(23'd4, 8'h70);
        drive_byte(23'd5, 8'h71);
        drive_byte(23'd6, 8'h72);
        tests_run++;
        if (prog_we !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre: prog_we got %b want 1", prog_we); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run += 2;
        if (prog_we !== 1'b0)    begin tests_failed++; $display("FAIL rmid_we: got %b want 0", prog_we); end
        if (dwnld_busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_busy: got %b want 1", dwnld_busy); end
        ack_auto = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (wlog.size() != 0) begin tests_failed++; $display("FAIL rmid_writes: got %0d want 0", wlog.size()); end
        downloading = 1'b0;
        tick();
        ack_auto = 1'b0;
        tests_run++;
        if (dwnld_busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_idle: got %b want 0", dwnld_busy); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_header_strip();
        test_overflow();
        test_slow_ack();
        test_rom_end();
        test_tail_timing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
